// File: rtl/rr_grant_arbiter16.sv
// rr_grant_arbiter16 -- round-robin arbiter for one shared 16-way select.
//
// A winner keeps its grant for as long as it holds its request. The grant is
// registered and presented both as an index and as the matching one-hot vector.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req        request vector, bit i = requester i (level sensitive)
//   arb_en     allows new grants to start; an existing grant is unaffected
//   gnt        one-hot grant, all-zero when idle (registered)
//   gnt_idx    index of the current holder, 0 when idle (registered)
//   gnt_valid  high while a grant is active (registered)
//   timeout    one-cycle pulse when a grant is forcibly revoked
//
// Optional feature, macro ARB_HOLD_TIMEOUT_EN: limits a holder to MAX_HOLD
// consecutive cycles. Without it, grants are unbounded and timeout is tied 0.

module rr_grant_arbiter16 #(
   parameter int N        = 16,
   parameter int IDX_W    = 4,
   parameter int MAX_HOLD = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N-1:0]     req,
   input  logic             arb_en,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             gnt_valid,
   output logic             timeout
);

   generate
      if (N != 16) begin : g_bad_n
         $error("rr_grant_arbiter16: N must be 16");
      end
      if (IDX_W != $clog2(N)) begin : g_bad_idx_w
         $error("rr_grant_arbiter16: IDX_W must equal log2(N)");
      end
      if (MAX_HOLD < 2 || MAX_HOLD > 65535) begin : g_bad_max_hold
         $error("rr_grant_arbiter16: MAX_HOLD must be 2..65535");
      end
   endgenerate

   typedef enum logic {IDLE, GRANT} state_t;

   state_t           state, state_nxt;
   logic [IDX_W-1:0] ptr, ptr_nxt;
   logic [IDX_W-1:0] idx_nxt;
   logic             valid_nxt;
   logic [N-1:0]     gnt_nxt;
   logic             new_grant;
   logic             win_found;
   logic [IDX_W-1:0] win_idx;
   logic [IDX_W-1:0] cand;
   logic             excl_en;
   logic             holder_req;
   logic             hold_expired;
   logic             revoke;

   // While a grant is active, the current holder is excluded from the search:
   // it either released (so its bit is low anyway) or is being revoked.
   assign excl_en    = (state == GRANT);
   assign holder_req = req[gnt_idx];
   assign revoke     = (state == GRANT) && holder_req && hold_expired;

   // Rotating search starting at ptr, ascending with wrap, first set bit wins.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int unsigned i = 0; i < N; i++) begin
         cand = ptr + IDX_W'(i);
         if (!win_found && req[cand] && !(excl_en && (cand == gnt_idx))) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      idx_nxt   = gnt_idx;
      valid_nxt = gnt_valid;
      new_grant = 1'b0;
      case (state)
         IDLE: begin
            if (arb_en && win_found) begin
               new_grant = 1'b1;
            end
         end
         GRANT: begin
            if (!holder_req || revoke) begin
               if (arb_en && win_found) begin
                  new_grant = 1'b1;
               end else begin
                  state_nxt = IDLE;
                  idx_nxt   = '0;
                  valid_nxt = 1'b0;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
            idx_nxt   = '0;
            valid_nxt = 1'b0;
         end
      endcase
      if (new_grant) begin
         state_nxt = GRANT;
         idx_nxt   = win_idx;
         valid_nxt = 1'b1;
         ptr_nxt   = win_idx + IDX_W'(1);
      end
      gnt_nxt = '0;
      if (valid_nxt) begin
         gnt_nxt[idx_nxt] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         ptr       <= '0;
         gnt       <= '0;
         gnt_idx   <= '0;
         gnt_valid <= 1'b0;
      end else begin
         state     <= state_nxt;
         ptr       <= ptr_nxt;
         gnt       <= gnt_nxt;
         gnt_idx   <= idx_nxt;
         gnt_valid <= valid_nxt;
      end
   end

`ifdef ARB_HOLD_TIMEOUT_EN
   logic [15:0] hold_cnt;

   // hold_cnt counts completed grant cycles minus one, so the edge that ends
   // the MAX_HOLD-th cycle sees hold_cnt == MAX_HOLD-1.
   assign hold_expired = (hold_cnt == 16'(MAX_HOLD - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_cnt <= '0;
         timeout  <= 1'b0;
      end else begin
         timeout <= revoke;
         if (new_grant) begin
            hold_cnt <= '0;
         end else if (state == GRANT) begin
            hold_cnt <= hold_cnt + 16'd1;
         end
      end
   end
`else
   assign hold_expired = 1'b0;
   assign timeout      = 1'b0;
`endif

endmodule

// File: tb/tb_rr_grant_arbiter16.sv
// Directed-vector bench for rr_grant_arbiter16 with a scoreboard queue:
// the driver pushes the expected post-edge outputs, the monitor pops and
// compares one entry after each rising edge. Runs with MAX_HOLD=8.

module tb_rr_grant_arbiter16;

   logic        clk;
   logic        rst_n;
   logic [15:0] req;
   logic        arb_en;
   logic [15:0] gnt;
   logic [3:0]  gnt_idx;
   logic        gnt_valid;
   logic        timeout;

   typedef struct packed {
      logic [3:0] idx;
      logic       valid;
      logic       tmo;
   } exp_t;

   exp_t exp_q[$];
   int   pass_cnt  = 0;
   int   check_cnt = 0;

   rr_grant_arbiter16 #(.N(16), .IDX_W(4), .MAX_HOLD(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .arb_en    (arb_en),
      .gnt       (gnt),
      .gnt_idx   (gnt_idx),
      .gnt_valid (gnt_valid),
      .timeout   (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] onehot(input logic [3:0] idx, input logic valid);
      logic [15:0] v;
      v = '0;
      if (valid) v[idx] = 1'b1;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
      check_cnt++;
      if (act === req_v) pass_cnt++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, req_v, $time);
   endtask

   // Drive one vector at the falling edge; expectation applies after the next rising edge.
   task automatic step(input logic [15:0] r, input logic en,
                       input logic [3:0] ei, input logic ev, input logic et);
      exp_t e;
      @(negedge clk);
      req    = r;
      arb_en = en;
      e.idx   = ei;
      e.valid = ev;
      e.tmo   = et;
      exp_q.push_back(e);
   endtask

   // Monitor
   always @(posedge clk) begin
      #1;
      if (rst_n && exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         check("gnt_idx",   32'(gnt_idx),   32'(e.idx));
         check("gnt_valid", 32'(gnt_valid), 32'(e.valid));
         check("gnt",       32'(gnt),       32'(onehot(e.idx, e.valid)));
         check("timeout",   32'(timeout),   32'(e.tmo));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n  = 1'b0;
      req    = '0;
      arb_en = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", {gnt, 11'd0, gnt_idx, gnt_valid}, 32'd0);
      check("reset_timeout", 32'(timeout), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // No requests: stays idle
      for (int i = 0; i < 5; i++) step(16'h0000, 1'b1, 4'd0, 1'b0, 1'b0);

      // Single requester 4, grant after one cycle, release one cycle after drop
      for (int i = 0; i < 5; i++) step(16'h0010, 1'b1, 4'd4, 1'b1, 1'b0);
      step(16'h0000, 1'b1, 4'd0, 1'b0, 1'b0);
      step(16'h0000, 1'b1, 4'd0, 1'b0, 1'b0);

      // Reset returns ptr to 0 before the fairness sweep
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // All requesting; each holder drops its bit for one cycle after two grant cycles
      step(16'hFFFF, 1'b1, 4'd0, 1'b1, 1'b0);
      for (int h = 0; h < 16; h++) begin
         logic [15:0] drop;
         drop = 16'hFFFF;
         drop[h] = 1'b0;
         step(16'hFFFF, 1'b1, 4'(h), 1'b1, 1'b0);
         step(drop, 1'b1, 4'((h + 1) % 16), 1'b1, 1'b0);
      end
      step(16'h0000, 1'b1, 4'd0, 1'b0, 1'b0);

      // Wrap-around: last winner 14, then 15 and 0 request
      step(16'h4000, 1'b1, 4'd14, 1'b1, 1'b0);
      step(16'h0000, 1'b1, 4'd0,  1'b0, 1'b0);
      step(16'h8001, 1'b1, 4'd15, 1'b1, 1'b0);
      step(16'h8001, 1'b1, 4'd15, 1'b1, 1'b0);
      step(16'h0001, 1'b1, 4'd0,  1'b1, 1'b0);
      step(16'h0001, 1'b1, 4'd0,  1'b1, 1'b0);
      step(16'h0000, 1'b1, 4'd0,  1'b0, 1'b0);

      // arb_en low while holding 3: held, then idle until arb_en returns
      step(16'h0008, 1'b1, 4'd3, 1'b1, 1'b0);
      step(16'hFFFF, 1'b0, 4'd3, 1'b1, 1'b0);
      step(16'hFFFF, 1'b0, 4'd3, 1'b1, 1'b0);
      step(16'hFFF7, 1'b0, 4'd0, 1'b0, 1'b0);
      step(16'hFFFF, 1'b0, 4'd0, 1'b0, 1'b0);
      step(16'hFFFF, 1'b1, 4'd4, 1'b1, 1'b0);
      step(16'h0000, 1'b1, 4'd0, 1'b0, 1'b0);

      // Two constant requesters (0 and 2), ptr=5 so 0 wins first
`ifdef ARB_HOLD_TIMEOUT_EN
      for (int i = 0; i < 8; i++) step(16'h0005, 1'b1, 4'd0, 1'b1, 1'b0);
      step(16'h0005, 1'b1, 4'd2, 1'b1, 1'b1);
      for (int i = 0; i < 7; i++) step(16'h0005, 1'b1, 4'd2, 1'b1, 1'b0);
      step(16'h0005, 1'b1, 4'd0, 1'b1, 1'b1);
      step(16'h0005, 1'b1, 4'd0, 1'b1, 1'b0);
      step(16'h0005, 1'b1, 4'd0, 1'b1, 1'b0);
`else
      for (int i = 0; i < 20; i++) step(16'h0005, 1'b1, 4'd0, 1'b1, 1'b0);
`endif

      // Asynchronous reset mid-grant clears outputs at once
      @(posedge clk);
      #3;
      check("pre_reset_valid", 32'(gnt_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      check("async_reset_gnt",   32'(gnt),       32'd0);
      check("async_reset_idx",   32'(gnt_idx),   32'd0);
      check("async_reset_valid", 32'(gnt_valid), 32'd0);
      check("async_reset_tmo",   32'(timeout),   32'd0);
      req = '0;
      @(negedge clk);
      rst_n = 1'b1;

      // First arbitration after reset starts from ptr 0
      step(16'hFFFF, 1'b1, 4'd0, 1'b1, 1'b0);
      step(16'h0000, 1'b1, 4'd0, 1'b0, 1'b0);

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      #3;
      check("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

   // Structural invariant on every cycle out of reset
   always @(negedge clk) begin
      if (rst_n) begin
         check("inv_onehot", 32'(gnt), 32'(onehot(gnt_idx, gnt_valid)));
         check("inv_valid",  32'(gnt_valid), 32'(|gnt));
      end
   end

endmodule

// File: doc/rr_grant_arbiter16.md
Name: rr_grant_arbiter16

Overview:
Round-robin arbiter that shares one 16-way one-hot select resource among 16 requesters.
- Grant is held for as long as the winner keeps its request asserted.
- Grant is presented both as a 4-bit index and as the matching decoded one-hot vector, which drives downstream select/enable lines directly.
- Sits between requesting channels and the shared bus/resource select.

Parameters:
- N, 16, number of requesters; fixed at 16 for this block, parameter kept for documentation and checks.
- IDX_W, 4, width of grant index; must equal log2(N).
- MAX_HOLD, 64, maximum consecutive grant cycles per holder; used only when ARB_HOLD_TIMEOUT_EN is defined; legal range 2..65535.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  16  request vector; bit i is requester i.
- arb_en  input  1  when high, new grants may be issued; when low, no new grant starts.
- gnt  output  16  one-hot grant; all-zero when no grant; registered.
- gnt_idx  output  4  index of the current holder; 0 when gnt_valid is low; registered.
- gnt_valid  output  1  high while any grant is active; registered.
- timeout  output  1  one-cycle pulse when a grant is forcibly revoked; constant 0 without the optional feature.

Behaviour:
- Reset (asynchronous, rst_n low):
  - gnt=0, gnt_idx=0, gnt_valid=0, timeout=0.
  - State=IDLE, rotation pointer ptr=0, hold counter=0.
- Invariants, checked every cycle:
  - gnt always equals the decode of gnt_idx when gnt_valid=1, and all zeros otherwise; never more than one bit set.
  - gnt_valid == |gnt.
- States:
  - IDLE: no grant.
  - GRANT: one holder.
- Arbitration function:
  - Search req starting at bit ptr, ascending, wrapping 15->0.
  - The first set bit wins.
  - The excluded index, if any, is skipped.
- IDLE -> GRANT: at an edge where arb_en=1 and req!=0.
  - gnt_idx=winner, gnt set; visible one cycle after req is sampled (latency 1).
  - ptr=winner+1 mod 16 (15 wraps to 0).
- GRANT, holder's req bit still high: grant is held unchanged regardless of other requests or arb_en.
- GRANT, holder's req bit low at an edge:
  - Holder is released.
  - If arb_en=1 and another req bit is set, the new winner is granted at that same edge. This is back-to-back; no idle cycle. The releasing requester is excluded for this arbitration.
  - Otherwise -> IDLE with gnt=0.
- arb_en falling while in GRANT: current grant continues until released; no re-arbitration while arb_en=0.
- Requests are level-sensitive. A requester dropping req before being granted is simply not considered. No queuing or memory of past requests.
- Fairness: with all 16 requesting continuously and each releasing after k cycles, grants rotate 0,1,2,...,15,0 with no requester skipped.
- Reset asserted mid-grant: outputs clear immediately (asynchronously). After rst_n deasserts, the first arbitration starts from ptr=0.

Optional Feature:
- Macro: ARB_HOLD_TIMEOUT_EN.
- When defined:
  - Hold counter increments each cycle in GRANT and clears on every new grant.
  - When the holder has been granted MAX_HOLD consecutive cycles and still requests, the grant is revoked at that edge and timeout pulses high for exactly 1 cycle, coincident with the revoke.
  - Re-arbitration happens at the same edge, excluding the revoked index; if nothing else requests, go to IDLE.
  - The revoked requester may win again on the following arbitration.
- When undefined: no counter is built, grants are unbounded, and timeout is tied 0.

Test Plan:
- Reset then req=16'h0000, arb_en=1 for 5 cycles -> gnt=0, gnt_valid=0, gnt_idx=0 throughout.
- req=16'h0010 at cycle 0 -> cycle 1: gnt=16'h0010, gnt_idx=4, gnt_valid=1. Drop req at cycle 5 -> gnt=0 at cycle 6.
- req=16'hFFFF held, each holder drops its bit for 1 cycle after 2 cycles of grant -> grant order 0,1,2,...,15,0 with back-to-back handover (gnt_valid never drops).
- ptr=15 (last winner 14), req=16'h8001 -> grant 15; on release, grant 0 (wrap-around).
- Holding grant 3 while arb_en dropped to 0 and req=16'hFFFF -> grant 3 held; on release gnt=0 until arb_en returns high, then grant 4 the cycle after.
- With ARB_HOLD_TIMEOUT_EN, MAX_HOLD=8, req=16'h0005 constantly -> grant 0 for 8 cycles, timeout pulse, grant 2 for 8 cycles, timeout pulse, grant 0 again. rst_n pulsed low mid-grant -> all outputs 0 immediately.
